nf_ram_copy: RTL and testbench

NF_RAM_COPY -- requirements
Module: nf_ram_copy

---
 rtl/nf_ram_copy.sv | 90 +++++++++
 tb/tb_nf_ram_copy.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nf_ram_copy.sv
// Word-by-word copier for an nf-style RAM with combinational read data.
// Reads one word and writes it in the next cycle, in ascending address order.
module nf_ram_copy #(
    parameter int depth = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [32:0] DEPTH33 = 33'(depth);

    logic [1:0]  state;
    logic [31:0] src_q, dst_q, cnt_q, data_q;
    logic [32:0] src_end, dst_end;
    logic        bad_req;

    // End addresses are formed in 33 bits so a huge len cannot wrap into range.
    assign src_end = {1'b0, src_addr} + {1'b0, len};
    assign dst_end = {1'b0, dst_addr} + {1'b0, len};
    assign bad_req = (len == 32'd0) || (src_end > DEPTH33) || (dst_end > DEPTH33);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            err    <= 1'b0;
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_q <= src_addr;
                    dst_q <= dst_addr;
                    cnt_q <= len;
                    err   <= bad_req;
                    state <= bad_req ? DONE : RD;
                end
                RD: begin
                    if (abort) begin
                        state <= DONE;
                    end else begin
                        data_q <= ram_rd;
                        state  <= WR;
                    end
                end
                WR: begin
                    src_q <= src_q + 32'd1;
                    dst_q <= dst_q + 32'd1;
                    cnt_q <= cnt_q - 32'd1;
                    state <= (abort || cnt_q == 32'd1) ? DONE : RD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable is gated by resetn so a reset landing on a WR cycle
    // cannot commit that write.
    always_comb begin
        busy     = (state == RD) || (state == WR);
        done     = (state == DONE);
        ram_we   = (state == WR) && resetn;
        ram_addr = '0;
        ram_wd   = '0;
        if (state == RD) ram_addr = src_q;
        if (state == WR) begin
            ram_addr = dst_q;
            ram_wd   = data_q;
        end
    end

endmodule

// File: tb/tb_nf_ram_copy.sv
// Scoreboard bench for nf_ram_copy: a RAM model, expected writes queued at
// start, compared as the DUT writes.
module tb_nf_ram_copy;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn, start, abort;
    logic [31:0] src_addr, dst_addr, len;
    logic        busy, done, err, ram_we;
    logic [31:0] ram_addr, ram_wd, ram_rd;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_a;
    logic [31:0] tb_d;

    wr_t sb[$];
    int  nchk = 0, npass = 0, wr_cnt = 0;

    nf_ram_copy #(.depth(64)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    assign ram_rd = mem[ram_addr[5:0]];
    always @(posedge clk) begin
        if (tb_we)       mem[tb_a] <= tb_d;
        else if (ram_we) mem[ram_addr[5:0]] <= ram_wd;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every RAM write observed must match the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (ram_we === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexp_wr", {ram_addr, ram_wd}, 64'hffff_ffff_ffff_ffff);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {32'd0, ram_addr}, {32'd0, e.a});
                chk("wr_data", {32'd0, ram_wd}, {32'd0, e.d});
            end
        end
    end

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_a = 6'(a); tb_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Drive a start; the reference model performs the first nexp copy steps.
    task automatic start_op(input int src, input int dst, input int n, input int nexp);
        wr_t e;
        @(negedge clk);
        src_addr = 32'(src); dst_addr = 32'(dst); len = 32'(n); start = 1'b1;
        for (int k = 0; k < nexp; k++) begin
            ref_mem[dst + k] = ref_mem[src + k];
            e.a = 32'(dst + k);
            e.d = ref_mem[dst + k];
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe cycles 1..maxc after the start edge; optional abort/reset cycle.
    task automatic run(input int abort_at, input int rst_at, input int maxc,
                       output int nbusy, output int done_at, output int ndone);
        nbusy = 0; done_at = 0; ndone = 0;
        for (int c = 1; c <= maxc; c++) begin
            abort  = (c == abort_at);
            resetn = (c != rst_at);
            #1;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (rst_at > 0 && c == rst_at + 1)
                chk("rst_outs", {29'd0, busy, done, err, ram_we, ram_addr}, 64'd0);
            @(negedge clk);
        end
        abort = 1'b0; resetn = 1'b1;
    endtask

    int nb, da, nd, w0;

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        tb_we = 1'b0; tb_a = '0; tb_d = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_outs", {29'd0, busy, done, err, ram_we, ram_addr}, 64'd0);
        chk("reset_wd", {32'd0, ram_wd}, 64'd0);
        resetn = 1'b1;
        for (int i = 0; i < 64; i++) poke(i, 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) poke(i, 32'hA0 + 32'(i));

        // Basic 4-word copy
        w0 = wr_cnt;
        start_op(0, 8, 4, 4);
        run(0, 0, 12, nb, da, nd);
        chk("basic_busy", 64'(nb), 64'd8);
        chk("basic_done_at", 64'(da), 64'd9);
        chk("basic_ndone", 64'(nd), 64'd1);
        chk("basic_err", {63'd0, err}, 64'd0);
        chk("basic_nwr", 64'(wr_cnt - w0), 64'd4);
        for (int k = 0; k < 4; k++) chk("basic_mem", {32'd0, mem[8 + k]}, 64'hA0 + 64'(k));

        // Source range overflow
        w0 = wr_cnt;
        start_op(60, 0, 5, 0);
        run(0, 0, 6, nb, da, nd);
        chk("ovf_busy", 64'(nb), 64'd0);
        chk("ovf_done_at", 64'(da), 64'd1);
        chk("ovf_ndone", 64'(nd), 64'd1);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_nwr", 64'(wr_cnt - w0), 64'd0);

        // Zero length, then a valid start clears err
        w0 = wr_cnt;
        start_op(5, 6, 0, 0);
        run(0, 0, 6, nb, da, nd);
        chk("len0_done_at", 64'(da), 64'd1);
        chk("len0_err", {63'd0, err}, 64'd1);
        chk("len0_nwr", 64'(wr_cnt - w0), 64'd0);

        // Forward overlap replicates word 0
        poke(0, 32'h11); poke(1, 32'h22);
        chk("err_sticky", {63'd0, err}, 64'd1);
        start_op(0, 1, 2, 2);
        run(0, 0, 8, nb, da, nd);
        chk("ovl_busy", 64'(nb), 64'd4);
        chk("ovl_done_at", 64'(da), 64'd5);
        chk("ovl_err_clr", {63'd0, err}, 64'd0);
        chk("ovl_mem1", {32'd0, mem[1]}, 64'h11);
        chk("ovl_mem2", {32'd0, mem[2]}, 64'h11);

        // Abort during second RD
        w0 = wr_cnt;
        start_op(16, 24, 4, 1);
        run(3, 0, 8, nb, da, nd);
        chk("abort_busy", 64'(nb), 64'd3);
        chk("abort_done_at", 64'(da), 64'd4);
        chk("abort_ndone", 64'(nd), 64'd1);
        chk("abort_nwr", 64'(wr_cnt - w0), 64'd1);
        chk("abort_mem25", {32'd0, mem[25]}, {32'd0, ref_mem[25]});
        chk("abort_idle", {62'd0, busy, err}, 64'd0);

        // Reset during second WR, then a fresh copy
        w0 = wr_cnt;
        start_op(32, 40, 4, 1);
        run(0, 4, 8, nb, da, nd);
        chk("rst_busy", 64'(nb), 64'd4);
        chk("rst_ndone", 64'(nd), 64'd0);
        chk("rst_nwr", 64'(wr_cnt - w0), 64'd1);
        chk("rst_mem41", {32'd0, mem[41]}, {32'd0, ref_mem[41]});
        start_op(32, 40, 4, 4);
        run(0, 0, 12, nb, da, nd);
        chk("fresh_busy", 64'(nb), 64'd8);
        chk("fresh_done_at", 64'(da), 64'd9);

        // Exact upper boundary: src+len == depth is legal
        start_op(60, 0, 4, 4);
        run(0, 0, 12, nb, da, nd);
        chk("edge_busy", 64'(nb), 64'd8);
        chk("edge_err", {63'd0, err}, 64'd0);
        chk("edge_mem3", {32'd0, mem[3]}, {32'd0, ref_mem[63]});

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
